// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory port between I_cache and D_cache (round-robin when ARB_RR_EN is defined, else fixed priority)
module mem_arbiter #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128,
  parameter int D_PRIORITY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;
  state_t state, state_nx;
  logic req_i, req_d, pick_d, start, finish;
  assign req_i  = i_read | i_write;
  assign req_d  = d_read | d_write;
  assign start  = (state == IDLE) & (req_i | req_d);
  assign finish = ((state == GNT_I) | (state == GNT_D)) & mem_ready;
  assign busy   = state != IDLE;
`ifdef ARB_RR_EN
  logic last_d;
  assign pick_d = req_d & (~req_i | ~last_d);
  // remember who was granted last so a tie goes to the other requester
  always_ff @(posedge clk)
    if (rst) last_d <= 1'b0;
    else if (start) last_d <= pick_d;
`else
  assign pick_d = req_d & (~req_i | (D_PRIORITY != 0));
`endif
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: a grant lasts until mem_ready, then one DONE cycle lets the requester drop its request
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (start ? (pick_d ? GNT_D : GNT_I) : IDLE) :
               (state == DONE) ? IDLE : (mem_ready ? DONE : state);
  end
  // latch the winner's command, then return data and a one-cycle ready to that requester only
  always_ff @(posedge clk)
    if (rst) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (start) begin
        mem_write <= pick_d ? d_write : i_write;
        mem_read  <= pick_d ? d_read & ~d_write : i_read & ~i_write;
        mem_addr  <= pick_d ? d_addr : i_addr;
        mem_wdata <= pick_d ? d_wdata : i_wdata;
      end
      if (finish) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        i_ready   <= state == GNT_I;
        d_ready   <= state == GNT_D;
        if (mem_read && state == GNT_I) i_rdata <= mem_rdata;
        if (mem_read && state == GNT_D) d_rdata <= mem_rdata;
      end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table and scoreboard bench for mem_arbiter with a fixed-latency memory model
module tb_mem_arbiter;
  localparam int AW = 28, DW = 128, LAT = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic i_rd = 0, i_wr = 0, d_rd = 0, d_wr = 0;
  logic [AW-1:0] ia = '0, da = '0;
  logic [DW-1:0] iwd = '0, dwd = '0;
  int i_gen = 0, i_dgen = 0, d_gen = 0, d_dgen = 0;
  logic i_read, i_write, d_read, d_write;
  assign i_read  = i_rd & (i_gen != i_dgen);
  assign i_write = i_wr & (i_gen != i_dgen);
  assign d_read  = d_rd & (d_gen != d_dgen);
  assign d_write = d_wr & (d_gen != d_dgen);
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic i_ready, d_ready, mem_read, mem_write, busy, mem_ready = 1'b0;
  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_addr(ia), .i_wdata(iwd), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(da), .d_wdata(dwd), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );
  typedef struct {logic d; logic rd; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wd;} txn_t;
  typedef struct {
    logic i_rd; logic i_wr; logic [AW-1:0] ia; logic [DW-1:0] iwd;
    logic d_rd; logic d_wr; logic [AW-1:0] da; logic [DW-1:0] dwd;
    logic d_first;
  } vec_t;
  txn_t q[$];
  txn_t mon_e;
  vec_t vecs[7];
  int n_vec = 0, n_err = 0;
  bit auto_mem = 0, stray = 0, last_d = 0;
  int cnt = 0, held = 0, hold_to = 0;
  logic [DW-1:0] trk_i = '0, trk_d = '0;
  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {{(DW-AW){1'b0}}, a} ^ 128'hB5;
  endfunction
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic push(input logic d, input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    q.push_back('{d, rd, wr, a, wd});
    last_d = d;
  endtask
  task automatic wait_empty();
    for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      chk("timeout_pending", q.size(), 0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic apply(input vec_t v);
    logic ri, rq, df;
    ri = v.i_rd | v.i_wr;
    rq = v.d_rd | v.d_wr;
`ifdef ARB_RR_EN
    df = ~last_d;
`else
    df = v.d_first;
`endif
    if (ri & rq & df) begin
      push(1, v.d_rd, v.d_wr, v.da, v.dwd);
      push(0, v.i_rd, v.i_wr, v.ia, v.iwd);
    end else if (ri & rq) begin
      push(0, v.i_rd, v.i_wr, v.ia, v.iwd);
      push(1, v.d_rd, v.d_wr, v.da, v.dwd);
    end else if (ri) push(0, v.i_rd, v.i_wr, v.ia, v.iwd);
    else if (rq) push(1, v.d_rd, v.d_wr, v.da, v.dwd);
    i_rd = v.i_rd; i_wr = v.i_wr; ia = v.ia; iwd = v.iwd;
    d_rd = v.d_rd; d_wr = v.d_wr; da = v.da; dwd = v.dwd;
    if (ri) i_gen++;
    if (rq) d_gen++;
    wait_empty();
  endtask
  // memory model: checks each new command against the scoreboard head, answers after LAT cycles
  always @(negedge clk) begin
    if (!auto_mem) begin
      mem_ready = stray;
      cnt = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      cnt = 0;
    end else if (mem_read | mem_write) begin
      if (cnt == 0) begin
        if (q.size() == 0) chk("mem_req_unexpected", {mem_read, mem_write}, 0);
        else begin
          chk("mem_cmd", {mem_read, mem_write}, {q[0].rd & ~q[0].wr, q[0].wr});
          chk("mem_addr", mem_addr, q[0].addr);
          if (q[0].wr) chk("mem_wdata", mem_wdata, q[0].wd);
        end
      end
      cnt++;
      if (cnt == LAT) begin
        mem_ready = 1'b1;
        mem_rdata = mem_data(mem_addr);
      end
    end
  end
  // ready monitor: pops the scoreboard, checks requester and data, then drops that requester's request
  always @(negedge clk) begin
    if (rst) begin
      trk_i = '0;
      trk_d = '0;
    end
    if (i_ready | d_ready) begin
      if (q.size() == 0 || (i_ready & d_ready)) chk("ready_unexpected", {i_ready, d_ready}, 0);
      else begin
        mon_e = q.pop_front();
        chk("ready_who", d_ready, mon_e.d);
        if (mon_e.rd & ~mon_e.wr) begin
          if (mon_e.d) trk_d = mem_data(mon_e.addr);
          else trk_i = mem_data(mon_e.addr);
        end
        if (mon_e.d) chk("d_rdata", d_rdata, trk_d);
        else chk("i_rdata", i_rdata, trk_i);
        if (held != hold_to) begin
          held++;
          if (held == hold_to) begin
            i_dgen = i_gen;
            d_dgen = d_gen;
          end
        end else if (d_ready) d_dgen = d_gen;
        else i_dgen = i_gen;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vecs = '{
      '{1, 0, 28'h0000010, 128'h0, 0, 0, 28'h0, 128'h0, 1},
      '{1, 0, 28'h0000010, 128'h0, 0, 1, 28'h0000020, 128'h1234, 1},
      '{0, 0, 28'h0, 128'h0, 1, 0, 28'hFFFFFFF, 128'h0, 1},
      '{0, 1, 28'h0000030, {128{1'b1}}, 0, 0, 28'h0, 128'h0, 1},
      '{1, 1, 28'h0000040, 128'h55, 0, 0, 28'h0, 128'h0, 1},
      '{1, 0, 28'h0000060, 128'h0, 1, 0, 28'h0000050, 128'h0, 1},
      '{1, 0, 28'h0000001, 128'h0, 1, 1, 28'h0000002, 128'hABCD, 1}
    };
    d_rd = 1; d_gen = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ctl", {mem_read, mem_write, busy, i_ready, d_ready}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rdata", {i_rdata | d_rdata}, 0);
    end
    rst = 0; d_rd = 0; auto_mem = 1;
    @(negedge clk);
    push(0, 1, 0, 28'h0000010, 0);
    i_rd = 1; i_wr = 0; ia = 28'h0000010; i_gen++;
    @(negedge clk);
    chk("t2_mem_read", {mem_read, mem_write}, 2'b10);
    chk("t2_mem_addr", mem_addr, 28'h0000010);
    chk("t2_busy", busy, 1);
    wait_empty();
    chk("t2_i_rdata", i_rdata, 128'hA5);
    chk("t2_d_rdata", d_rdata, 0);
    auto_mem = 0; stray = 1;
    @(negedge clk);
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_stray", {busy, i_ready, d_ready}, 0);
    end
    auto_mem = 1;
    foreach (vecs[k]) apply(vecs[k]);
    auto_mem = 0;
    d_rd = 1; d_wr = 0; da = 28'h0000090; d_gen++;
    repeat (2) @(negedge clk);
    chk("t5_mem_read_before", {mem_read, busy}, 2'b11);
    rst = 1;
    @(negedge clk);
    chk("t5_mem_read_after", {mem_read, mem_write, busy}, 0);
    rst = 0; d_rd = 0; last_d = 0;
    repeat (6) begin
      @(negedge clk);
      chk("t5_no_ready", {i_ready, d_ready, busy}, 0);
    end
    auto_mem = 1;
    apply('{1, 0, 28'h0000100, 128'h0, 0, 0, 28'h0, 128'h0, 1});
    chk("t5_i_rdata", i_rdata, mem_data(28'h0000100));
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      push(~last_d, 1, 0, ~last_d ? 28'h0000070 : 28'h0000080, 0);
`else
      push(1, 1, 0, 28'h0000070, 0);
`endif
    end
    hold_to = held + 4;
    i_rd = 1; i_wr = 0; ia = 28'h0000080; i_gen++;
    d_rd = 1; d_wr = 0; da = 28'h0000070; d_gen++;
    wait_empty();
    repeat (4) @(negedge clk);
    chk("end_idle", {busy, mem_read, mem_write}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
